r408_dbus_mailbox: RTL

// - D-bus target (responder) for the R408 I/O processor's data port. Sits on addr/wdata/rdata/write/read/rdy.
// - Two byte FIFOs: RX (host->IOP) and TX (IOP->host). The IOP reaches both through a 16-byte register window.
// - Generates rdy with programmable wait states and raises an interrupt toward the IOP int inputs.

---
 rtl/r408_dbus_mailbox_pkg.sv | 23 ++
 rtl/r408_dbus_mailbox_if.sv | 13 +
 rtl/r408_sync_fifo.sv | 55 +++++
 rtl/r408_dbus_mailbox.sv | 131 +++++++++++++
 4 files changed

// File: rtl/r408_dbus_mailbox_pkg.sv
// Shared constants for the R408 D-bus mailbox: register offsets, STATUS bit
// positions and the bus-target FSM encoding.
package r408_dbus_pkg;

  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h1;
  localparam logic [3:0] OFS_RXCNT  = 4'h2;
  localparam logic [3:0] OFS_TXCNT  = 4'h3;
  localparam logic [3:0] OFS_IRQEN  = 4'h4;

  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_TX_NFULL  = 1;
  localparam int ST_RX_OVF    = 2;
  localparam int ST_TX_EMPTY  = 3;
  localparam int ST_TX_OVF    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/r408_dbus_mailbox_if.sv
// R408 D-bus data port. The initiator raises read or write and holds addr, wdata
// and the strobe stable until it samples rdy=1; rdy is a one-cycle completion pulse.
interface r408_dbus_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        read;
  logic        write;
  logic [7:0]  rdata;
  logic        rdy;

  modport master (output addr, wdata, read, write, input rdata, rdy);
  modport slave  (input addr, wdata, read, write, output rdata, rdy);
endinterface

// File: rtl/r408_sync_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; otherwise it is dropped and ovf pulses.
module r408_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign ovf       = push & full & ~w_do_pop;
  assign count     = r_count;
  assign head      = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/r408_dbus_mailbox.sv
// D-bus target giving the R408 IOP a 16-byte register window onto an RX FIFO
// (host->IOP) and a TX FIFO (IOP->host), with wait-state rdy and a level irq.
module r408_dbus_mailbox
  import r408_dbus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          DEPTH_LOG2  = 3,
  parameter int          WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  r408_dbus_if.slave    dbus,
  output logic          irq,
  input  logic [7:0]    host_wdata,
  input  logic          host_push,
  output logic          host_full,
  output logic [7:0]    host_rdata,
  output logic          host_valid,
  input  logic          host_pop,
  output state_t        o_dbg_state
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t              r_state, w_next;
  logic [3:0]          r_wcnt, w_wcnt_next;
  logic [7:0]          r_rdata, w_rd_data;
  logic                r_ack_wr, r_pop_ok, r_rx_ovf, r_tx_ovf, r_irq;
  logic [3:0]          r_ack_ofs;
  logic [7:0]          r_ack_wdata;
  logic [1:0]          r_irq_en;
  logic                w_strobe, w_sel, w_commit, w_tx_push, w_rx_pop, w_st_wr, w_en_wr;
  logic                w_rx_full, w_rx_empty, w_rx_ovf, w_tx_full, w_tx_empty, w_tx_ovf;
  logic [DEPTH_LOG2:0] w_rx_count, w_tx_count;
  logic [7:0]          w_rx_head;

  assign w_strobe = dbus.read | dbus.write;
  assign w_sel    = (dbus.addr[15:4] == BASE_ADDR[15:4]);

  always_comb begin
    w_next      = r_state;
    w_wcnt_next = r_wcnt;
    case (r_state)
      S_IDLE: if (w_sel && w_strobe) begin
        if (WS == 4'd0) w_next = S_ACK;
        else begin
          w_next      = S_WAIT;
          w_wcnt_next = WS - 4'd1;
        end
      end
      S_WAIT: begin
        if (!w_strobe)            w_next = S_IDLE;
        else if (r_wcnt == 4'd0)  w_next = S_ACK;
        else                      w_wcnt_next = r_wcnt - 4'd1;
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (dbus.addr[3:0])
      OFS_DATA:   w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
      OFS_STATUS: w_rd_data = {3'b000, r_tx_ovf, w_tx_empty, r_rx_ovf, ~w_tx_full, ~w_rx_empty};
      OFS_RXCNT:  w_rd_data = 8'(w_rx_count);
      OFS_TXCNT:  w_rd_data = 8'(w_tx_count);
      OFS_IRQEN:  w_rd_data = {6'b0, r_irq_en};
      default:    w_rd_data = 8'h00;
    endcase
  end

  // The access is captured on entry to ACK so its side effects at the end of
  // ACK match exactly what was returned, even if the host touches a FIFO meanwhile.
  assign w_commit  = (r_state == S_ACK);
  assign w_tx_push = w_commit & r_ack_wr & (r_ack_ofs == OFS_DATA);
  assign w_rx_pop  = w_commit & r_pop_ok;
  assign w_st_wr   = w_commit & r_ack_wr & (r_ack_ofs == OFS_STATUS);
  assign w_en_wr   = w_commit & r_ack_wr & (r_ack_ofs == OFS_IRQEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= 4'd0;
      r_rdata     <= 8'h00;
      r_ack_wr    <= 1'b0;
      r_ack_ofs   <= 4'd0;
      r_ack_wdata <= 8'h00;
      r_pop_ok    <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_irq_en    <= 2'b00;
      r_irq       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_next;
      if (w_next == S_ACK) begin
        r_ack_wr    <= dbus.write;
        r_ack_ofs   <= dbus.addr[3:0];
        r_ack_wdata <= dbus.wdata;
        r_rdata     <= dbus.write ? 8'h00 : w_rd_data;
        r_pop_ok    <= ~dbus.write & (dbus.addr[3:0] == OFS_DATA) & ~w_rx_empty;
      end else begin
        r_rdata  <= 8'h00;
        r_pop_ok <= 1'b0;
      end
      r_rx_ovf <= w_rx_ovf | (r_rx_ovf & ~(w_st_wr & r_ack_wdata[ST_RX_OVF]));
      r_tx_ovf <= w_tx_ovf | (r_tx_ovf & ~(w_st_wr & r_ack_wdata[ST_TX_OVF]));
      if (w_en_wr) r_irq_en <= r_ack_wdata[1:0];
      r_irq <= (r_irq_en[0] & ~w_rx_empty) | (r_irq_en[1] & w_tx_empty);
    end
  end

  r408_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .clk(clk), .rst(rst), .push(host_push), .wdata(host_wdata), .pop(w_rx_pop),
    .full(w_rx_full), .empty(w_rx_empty), .ovf(w_rx_ovf), .count(w_rx_count),
    .head(w_rx_head)
  );

  r408_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .clk(clk), .rst(rst), .push(w_tx_push), .wdata(r_ack_wdata), .pop(host_pop),
    .full(w_tx_full), .empty(w_tx_empty), .ovf(w_tx_ovf), .count(w_tx_count),
    .head(host_rdata)
  );

  assign dbus.rdy    = (r_state == S_ACK);
  assign dbus.rdata  = r_rdata;
  assign irq         = r_irq;
  assign host_full   = w_rx_full;
  assign host_valid  = ~w_tx_empty;
  assign o_dbg_state = r_state;
endmodule
